// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: a direct-mapped BTB with a 2-bit saturating counter per entry.
// Lookup is combinational on pc_i. The execute stage trains the table with resolved branch outcomes.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              isbranch_o,
  output logic [ADDR_W-1:0] branch_addr_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam int unsigned CTR_W = 2;

  localparam logic [CTR_W-1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [CTR_W-1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [CTR_W-1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [CTR_W-1:0] CTR_STRONG_T  = 2'b11;

  // Per-entry storage, kept in flops so every entry can be reset and flushed at once
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;

  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_hit;
  logic [CTR_W-1:0]  upd_ctr_cur;
  logic [CTR_W-1:0]  upd_ctr_nxt;

  // Byte-offset bits take no part in indexing or tagging
  logic unused_lsb;
  assign unused_lsb = ^{pc_i[1:0], upd_pc_i[1:0]};

  // Lookup: the prediction reflects table contents before any update in this cycle
  always_comb begin
    lk_idx        = pc_i[IDX_W+1:2];
    lk_tag        = pc_i[ADDR_W-1:IDX_W+2];
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    isbranch_o    = lk_hit && ctr_q[lk_idx][1];
    branch_addr_o = '0;
    if (isbranch_o) begin
      branch_addr_o = target_q[lk_idx];
    end
  end

  // Training: decode the update address and compute the saturating counter step
  always_comb begin
    upd_idx     = upd_pc_i[IDX_W+1:2];
    upd_tag     = upd_pc_i[ADDR_W-1:IDX_W+2];
    upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr_cur = ctr_q[upd_idx];
    upd_ctr_nxt = upd_ctr_cur;
    if (upd_taken_i) begin
      if (upd_ctr_cur != CTR_STRONG_T) begin
        upd_ctr_nxt = CTR_W'(upd_ctr_cur + CTR_W'(1));
      end
    end else begin
      if (upd_ctr_cur != CTR_STRONG_NT) begin
        upd_ctr_nxt = CTR_W'(upd_ctr_cur - CTR_W'(1));
      end
    end
  end

  // Table write port: reset, flush (clears valid bits only), and otherwise a single update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WEAK_NT;
      end
    end else if (flush_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_ctr_nxt;
        if (upd_taken_i) begin
          target_q[upd_idx] <= upd_target_i;
        end
      end else if (upd_taken_i) begin
        // A taken miss replaces the occupant and starts it at weakly taken
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target_i;
        ctr_q[upd_idx]    <= CTR_WEAK_T;
      end
    end
  end

endmodule
